mul_share_arbiter: RTL and testbench

Time-multiplexes one 4x4 unsigned nibble multiplier between two requesters, each needing a full 8x8 unsigned product. The FSM sequences four partial products through the shared multiplier and accumulates the result, so a single small multiplier serves both the x and y channels of the Monte Carlo estimator. It sits between the random-operand sources and the hit-test adder, and replaces ad-hoc state counters that drive the multiplier directly.

---
 rtl/mul_share_pkg.sv | 17 +
 rtl/nib_mul4.sv | 12 +
 rtl/mul_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_mul_share_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and sizes for the time-shared nibble multiplier arbiter.
package mul_share_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned NIB    = 4;
    localparam int unsigned PROD_W = 16;

    // IDLE waits for a grant; P0..P3 each push one partial product through the multiplier
    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3
    } state_e;

endpackage

// File: rtl/nib_mul4.sv
// Purely combinational 4x4 unsigned multiplier; the single shared resource.
module nib_mul4
    import mul_share_pkg::*;
(
    input  logic [NIB-1:0]   a_i,
    input  logic [NIB-1:0]   b_i,
    output logic [2*NIB-1:0] p_o
);

    assign p_o = {{NIB{1'b0}}, a_i} * {{NIB{1'b0}}, b_i};

endmodule

// File: rtl/mul_share_arbiter.sv
// Arbitrates two 8x8 multiply requests onto one 4x4 multiplier, sequencing the four
// partial products over P0..P3 and accumulating them into a 16-bit product.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                busy,
    output logic [PROD_W-1:0]   prod,
    output logic                prod_valid,
    output logic                prod_id
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [7:0]          a_q, a_d;
    logic [7:0]          b_q, b_d;
    logic                id_q, id_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                prod_valid_q, prod_valid_d;
    logic                prod_id_q, prod_id_d;

    logic [NREQ-1:0]     grant;
    logic [NIB-1:0]      mul_a, mul_b;
    logic [2*NIB-1:0]    mul_p;

    // Pick a winner among valid requesters; on contention round-robin favours the one
    // not granted last, fixed priority always favours requester 0.
    always_comb begin
        grant = '0;
        if (req_valid[0] && req_valid[1]) begin
            grant = (ROUND_ROBIN && !last_grant_q) ? 2'b10 : 2'b01;
        end else if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end

    assign req_ready  = (state_q == IDLE && en && !rst) ? grant : '0;
    assign busy       = (state_q != IDLE);
    assign prod       = prod_q;
    assign prod_valid = prod_valid_q;
    assign prod_id    = prod_id_q;

    // Route the nibble pair for the current partial product into the shared multiplier.
    always_comb begin
        mul_a = a_q[3:0];
        mul_b = b_q[3:0];
        unique case (state_q)
            P1: begin
                mul_a = a_q[7:4];
                mul_b = b_q[3:0];
            end
            P2: begin
                mul_a = a_q[3:0];
                mul_b = b_q[7:4];
            end
            P3: begin
                mul_a = a_q[7:4];
                mul_b = b_q[7:4];
            end
            default: begin
                mul_a = a_q[3:0];
                mul_b = b_q[3:0];
            end
        endcase
    end

    nib_mul4 u_nib_mul4 (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Next-state: accept in IDLE, accumulate shifted partials, publish the sum from P3.
    // With en low everything holds except the one-cycle prod_valid pulse.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        prod_id_d    = prod_id_q;
        prod_valid_d = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        a_d          = req_ready[1] ? req_a[15:8] : req_a[7:0];
                        b_d          = req_ready[1] ? req_b[15:8] : req_b[7:0];
                        id_d         = req_ready[1];
                        last_grant_d = req_ready[1];
                        state_d      = P0;
                    end
                end
                P0: begin
                    acc_d   = {8'b0, mul_p};
                    state_d = P1;
                end
                P1: begin
                    acc_d   = acc_q + {4'b0, mul_p, 4'b0};
                    state_d = P2;
                end
                P2: begin
                    acc_d   = acc_q + {4'b0, mul_p, 4'b0};
                    state_d = P3;
                end
                P3: begin
                    prod_d       = acc_q + {mul_p, 8'b0};
                    prod_id_d    = id_q;
                    prod_valid_d = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register; reset aborts any operation in flight without a prod_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            prod_id_q    <= prod_id_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench: two DUTs (round-robin and fixed priority) share stimulus; monitors
// push a*b on every observed handshake and pop/compare on every prod_valid.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [1:0]  req_ready, req_ready_fp;
    logic        busy, busy_fp;
    logic [15:0] prod, prod_fp;
    logic        prod_valid, prod_valid_fp;
    logic        prod_id, prod_id_fp;

    always #5 clk = ~clk;

    mul_share_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk (clk), .rst (rst), .en (en),
        .req_valid (req_valid), .req_a (req_a), .req_b (req_b),
        .req_ready (req_ready), .busy (busy),
        .prod (prod), .prod_valid (prod_valid), .prod_id (prod_id)
    );

    mul_share_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk (clk), .rst (rst), .en (en),
        .req_valid (req_valid), .req_a (req_a), .req_b (req_b),
        .req_ready (req_ready_fp), .busy (busy_fp),
        .prod (prod_fp), .prod_valid (prod_valid_fp), .prod_id (prod_id_fp)
    );

    typedef struct {
        logic        id;
        logic [15:0] p;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        fp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          n_flush = 0;
    logic        m_last;
    logic [15:0] m_prod;
    logic        m_id;
    logic [1:0]  acc_flag = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] lane(input logic [15:0] bus, input logic sel);
        return sel ? bus[15:8] : bus[7:0];
    endfunction

    // Reference arbitration: lone valid wins; on contention the one not served last wins
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        if (v[0]) return 2'b01;
        if (v[1]) return 2'b10;
        return 2'b00;
    endfunction

    // Monitor for the round-robin instance
    always @(negedge clk) begin : mon_main
        exp_t        e;
        logic [1:0]  g;
        logic        gid;
        logic [15:0] prd;
        cyc++;
        acc_flag = 2'b00;
        if (rst) begin
            check("ready_in_reset", 32'(req_ready), 32'(0));
            n_flush += exp_q.size();
            exp_q.delete();
            stalls = 0;
            m_last = 1'b1;
            m_prod = '0;
            m_id   = 1'b0;
        end else begin
            if (prod_valid && exp_q.size() == 0) begin
                check("no_spurious_prod_valid", 32'(prod_valid), 32'(0));
            end else if (prod_valid) begin
                e = exp_q.pop_front();
                n_done++;
                check("prod", 32'(prod), 32'(e.p));
                check("prod_id", 32'(prod_id), 32'(e.id));
                check("latency", cyc - e.cyc, 5 + stalls);
                m_prod = e.p;
                m_id   = e.id;
            end
            check("prod_hold", 32'(prod), 32'(m_prod));
            check("prod_id_hold", 32'(prod_id), 32'(m_id));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            g = (exp_q.size() == 0 && en) ? rr_pick(req_valid, m_last) : 2'b00;
            check("grant", 32'(req_ready), 32'(g));
            if ((req_valid & req_ready) != 2'b00) begin
                gid = req_ready[1];
                prd = {8'b0, lane(req_a, gid)} * {8'b0, lane(req_b, gid)};
                exp_q.push_back('{id: gid, p: prd, cyc: cyc});
                m_last   = gid;
                stalls   = 0;
                n_acc++;
                acc_flag = req_valid & req_ready;
            end else if (exp_q.size() != 0 && !en) begin
                stalls++;
            end
        end
    end

    // Monitor for the fixed-priority instance
    always @(negedge clk) begin : mon_fp
        exp_t        f;
        logic [1:0]  g;
        logic        gid;
        logic [15:0] prd;
        if (rst) begin
            fp_q.delete();
        end else begin
            if (prod_valid_fp && fp_q.size() == 0) begin
                check("fp_no_spurious", 32'(prod_valid_fp), 32'(0));
            end else if (prod_valid_fp) begin
                f = fp_q.pop_front();
                check("fp_prod", 32'(prod_fp), 32'(f.p));
                check("fp_prod_id", 32'(prod_id_fp), 32'(f.id));
            end
            check("fp_busy", 32'(busy_fp), 32'(fp_q.size() != 0));
            g = 2'b00;
            if (fp_q.size() == 0 && en) g = req_valid[0] ? 2'b01 : (req_valid[1] ? 2'b10 : 2'b00);
            check("fp_grant", 32'(req_ready_fp), 32'(g));
            if ((req_valid & req_ready_fp) != 2'b00) begin
                gid = req_ready_fp[1];
                prd = {8'b0, lane(req_a, gid)} * {8'b0, lane(req_b, gid)};
                fp_q.push_back('{id: gid, p: prd, cyc: cyc});
            end
        end
    end

    // One stimulus step: refresh a requester after it was served (or while idle)
    task automatic drive_cycle(input bit keep_valid, input bit rand_en);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_flag[i] || !req_valid[i]) begin
                req_valid[i]      = keep_valid ? 1'b1 : ($urandom_range(0, 1) == 1);
                req_a[i*8 +: 8]   = 8'($urandom);
                req_b[i*8 +: 8]   = 8'($urandom);
            end
        end
        en = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((exp_q.size() != 0 || fp_q.size() != 0) && k < 100);
        check("drain", exp_q.size(), 0);
    endtask

    // Directed single request with optional en-low stall starting in P1
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] want, input int stall);
        bit  seen;
        time t0;
        @(posedge clk);
        #1;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = req_ready[id];
        end
        check("dir_accept", 32'(seen), 32'(1));
        t0 = $time;
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        if (stall > 0) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            req_valid[1-id] = 1'b1;
            repeat (stall) @(posedge clk);
            #1;
            en = 1'b1;
            req_valid[1-id] = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = prod_valid;
        end
        check("dir_done", 32'(seen), 32'(1));
        check("dir_latency", 32'(($time - t0) / 10), 32'(5 + stall));
        check("dir_prod", 32'(prod), 32'(want));
        check("dir_id", 32'(prod_id), 32'(id));
    endtask

    initial begin
        int base;
        int guard;
        rst = 1'b1;
        en = 1'b1;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_prod", 32'(prod), 32'(0));
        check("rst_prod_id", 32'(prod_id), 32'(0));
        check("rst_prod_valid", 32'(prod_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 8'h12, 8'h34, 16'h03A8, 0);
        issue(1, 8'hFF, 8'hFF, 16'hFE01, 0);
        issue(0, 8'h00, 8'hFF, 16'h0000, 0);

        // Continuous contention: one acceptance every 5 cycles
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        base = n_acc;
        repeat (40) drive_cycle(1'b1, 1'b0);
        check("contention_throughput", n_acc - base, 8);
        req_valid = 2'b00;
        wait_idle();

        // Reset in P2 aborts the operation
        @(posedge clk);
        #1;
        req_a[7:0] = 8'h80;
        req_b[7:0] = 8'h80;
        req_valid[0] = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready[0] && guard < 20);
        check("abort_accept", 32'(req_ready[0]), 32'(1));
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_valid", 32'(prod_valid), 32'(0));
        check("abort_prod", 32'(prod), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check("abort_first_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        issue(0, 8'hA5, 8'h3C, 16'h26AC, 3);
        wait_idle();

        // Random phase: 1000 accepted operations with random enable
        base = n_acc;
        for (guard = 0; guard < 40000 && (n_acc - base) < 1000; guard++) begin
            drive_cycle(1'b0, 1'b1);
        end
        check("random_ops", 32'((n_acc - base) >= 1000), 32'(1));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        en = 1'b1;
        wait_idle();
        check("no_drop_dup", n_done + n_flush, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
